exe_stage: RTL
==============

Name: exe_stage

Overview:
- Execute stage of the 5-stage MIPS32 pipeline. It consumes the `exe_*` bundle from the ID/EXE register and produces the bundle for the EXE/MEM register.
- Arithmetic, logic, shift, move and jump results are combinational, as is single-cycle MULT/MULTU.
- DIV/DIVU use an iterative 32-step restoring divider FSM. While it runs, the stage raises `stallreq_exe`; the stall controller then drives `stall = 4'b1111`, which freezes PC, IF/ID, ID/EXE and this stage.

Parameters:
- DIV_STEPS, 32, radix-2 iterations per divide (fixed for 32-bit operands).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- exe_alutype  in  3  ALU class from ID/EXE
- exe_aluop  in  8  ALU opcode from ID/EXE
- exe_src1, exe_src2  in  32 each  operands
- exe_wa  in  5  destination register
- exe_wreg, exe_mreg, exe_whilo  in  1 each  write-enable and memory flags
- exe_din  in  32  store data
- exe_ret_addr  in  32  link address for jumps
- hi_i, lo_i  in  32 each  architectural HI/LO
- mem2exe_whilo  in  1  MEM-stage HI/LO write pending
- mem2exe_hilo  in  64  MEM-stage {hi,lo} value
- exe_aluop_o  out  8  opcode passed to EXE/MEM
- exe_wa_o  out  5  destination register
- exe_wreg_o, exe_mreg_o, exe_whilo_o  out  1 each  flags passed to EXE/MEM
- exe_wd_o  out  32  register write data
- exe_din_o  out  32  store data
- exe_hilo_o  out  64  {hi,lo} write data
- stallreq_exe  out  1  stall request to the stall controller

Behaviour:
- Reset: clk, synchronous, active-high `rst`.
  - Effect: FSM returns to IDLE, step counter 0, divider datapath cleared.
  - While `rst` is high, all outputs are forced to 0, including `stallreq_exe`.
  - A reset mid-divide aborts the divide; no partial result appears.
- Combinational results: `exe_wd_o` is selected by `exe_alutype`.
  - ARITH: ADD/ADDU/SUB/SLT/SLTU, computed mod 2^32. No overflow trap.
  - LOGIC: AND/OR/XOR/NOR/LUI.
  - SHIFT: shift amount is `exe_src1[4:0]`.
  - MOVE: MFHI/MFLO. HI/LO source is `mem2exe_hilo` when `mem2exe_whilo` is 1, else `hi_i`/`lo_i`.
  - JUMP: `exe_ret_addr`.
  - NOP: 0.
- Pass-through: `exe_wa`, `exe_wreg`, `exe_mreg`, `exe_din`, `exe_aluop` and `exe_whilo` go to their outputs, except that `exe_whilo_o` is forced to 0 while a divide is not in DONE.
- MULT/MULTU: 64-bit signed/unsigned product on `exe_hilo_o` in the same cycle. No stall.
- Divider FSM states: IDLE, BUSY, DONE.
  - IDLE with `exe_aluop` DIV/DIVU, divisor ≠ 0: latch |dividend|, |divisor| (raw values for DIVU) and the sign info. `stallreq_exe=1`. Next state BUSY, count 0.
  - IDLE with divisor = 0: `stallreq_exe=1`. Next state DONE, result quotient `32'hFFFF_FFFF`, remainder = dividend.
  - BUSY: one restoring step per cycle, `stallreq_exe=1`. After step DIV_STEPS-1, go to DONE.
  - DONE: `stallreq_exe=0` and `exe_hilo_o = {remainder, quotient}`.
    - The pipeline advances at the next edge; next state is IDLE.
    - A DIV entering in that IDLE starts normally, so back-to-back divides need no gap.
  - BUSY/DONE with `exe_aluop` no longer DIV/DIVU (defensive): return to IDLE, `stallreq_exe=0`.
- Signed fixup: the quotient is negated when the operand signs differ; the remainder takes the sign of the dividend.
  - `0x8000_0000 / -1` gives quotient `0x8000_0000`, remainder 0.
- Timing: divide occupancy is 34 cycles (33 with stall, 1 DONE). A divide-by-zero occupies 2 cycles.
- Stall inputs are not used here. This stage relies on ID/EXE holding `exe_*` constant while `stallreq_exe` is asserted.

Decomposition:
- Shared package `mips32_defs`:
  - ALUTYPE codes: NOP 3'b000, ARITH 001, LOGIC 010, MOVE 011, SHIFT 100, JUMP 101.
  - aluop codes, including the NOP bubble 8'h16, MULT 8'h14, MULTU 8'h15, DIV 8'h1A, DIVU 8'h1B.
  - FSM state encodings.
- One sub-module, `div_iter`: start/signed/operands in; busy/done/quotient/remainder out. It holds the FSM, counter and restoring datapath. `exe_stage` instantiates it and muxes the outputs.

Test Plan:
- ADDU `0xFFFF_FFFF + 1` -> `exe_wd_o = 0`, `stallreq_exe = 0` in the same cycle. SLT `-1 < 1` -> 1.
- MULT `-3 × 7` -> `exe_hilo_o = 64'hFFFF_FFFF_FFFF_FFEB`, `exe_whilo_o = 1`, no stall.
- DIV `-7 / 2` held 34 cycles -> `stallreq_exe` high for exactly 33 cycles, then the DONE cycle shows `hilo = {0xFFFF_FFFF, 0xFFFF_FFFD}`. DIVU `100/7` -> `{2, 14}`.
- DIV by 0 (`5/0`) -> 1 stall cycle, then `{5, 0xFFFF_FFFF}`. `0x8000_0000 / -1` -> `{0, 0x8000_0000}`.
- MFHI with `mem2exe_whilo = 1`, `mem2exe_hilo = {0x1234, 0x5678}`, `hi_i = 0xAAAA` -> `exe_wd_o = 0x1234`.
- `rst` pulsed at BUSY step 10, then a new DIVU `9/3` -> outputs 0 during reset, then a full 34-cycle divide giving `{0, 3}`. Back-to-back DIVs produce no dropped or merged results.

Source files
------------

// File: rtl/mips32_defs.sv
// Shared MIPS32 pipeline definitions: ALU class and opcode encodings, divider FSM states.
package mips32_defs;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned DIV_STEPS = 32;
  localparam int unsigned CNT_W     = $clog2(DIV_STEPS);

  localparam logic [2:0] ALUTYPE_NOP   = 3'b000;
  localparam logic [2:0] ALUTYPE_ARITH = 3'b001;
  localparam logic [2:0] ALUTYPE_LOGIC = 3'b010;
  localparam logic [2:0] ALUTYPE_MOVE  = 3'b011;
  localparam logic [2:0] ALUTYPE_SHIFT = 3'b100;
  localparam logic [2:0] ALUTYPE_JUMP  = 3'b101;

  localparam logic [7:0] ALU_LUI   = 8'h05;
  localparam logic [7:0] ALU_MFHI  = 8'h0C;
  localparam logic [7:0] ALU_MFLO  = 8'h0D;
  localparam logic [7:0] ALU_SLL   = 8'h11;
  localparam logic [7:0] ALU_SRL   = 8'h12;
  localparam logic [7:0] ALU_SRA   = 8'h13;
  localparam logic [7:0] ALU_MULT  = 8'h14;
  localparam logic [7:0] ALU_MULTU = 8'h15;
  localparam logic [7:0] ALU_NOP   = 8'h16;
  localparam logic [7:0] ALU_ADD   = 8'h18;
  localparam logic [7:0] ALU_ADDU  = 8'h19;
  localparam logic [7:0] ALU_DIV   = 8'h1A;
  localparam logic [7:0] ALU_DIVU  = 8'h1B;
  localparam logic [7:0] ALU_SUB   = 8'h1C;
  localparam logic [7:0] ALU_SUBU  = 8'h1D;
  localparam logic [7:0] ALU_AND   = 8'h1E;
  localparam logic [7:0] ALU_OR    = 8'h1F;
  localparam logic [7:0] ALU_XOR   = 8'h20;
  localparam logic [7:0] ALU_NOR   = 8'h21;
  localparam logic [7:0] ALU_SLT   = 8'h26;
  localparam logic [7:0] ALU_SLTU  = 8'h27;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'b00,
    DIV_BUSY = 2'b01,
    DIV_DONE = 2'b10
  } div_state_e;

  function automatic logic is_div(input logic [7:0] op);
    return (op == ALU_DIV) || (op == ALU_DIVU);
  endfunction

endpackage

// File: rtl/div_iter.sv
// Iterative 32-step restoring divider with sign fixup; start is a level held for the whole divide.
module div_iter
  import mips32_defs::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_start,
  input  logic        i_signed,
  input  logic [31:0] i_dividend,
  input  logic [31:0] i_divisor,
  output logic        o_busy,
  output logic        o_done,
  output logic [31:0] o_quotient,
  output logic [31:0] o_remainder
);

  div_state_e       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [XLEN-1:0]  r_quo;
  logic [XLEN-1:0]  r_rem;
  logic [XLEN-1:0]  r_dvs;
  logic             r_neg_q;
  logic             r_neg_r;

  logic             w_dvd_neg;
  logic             w_dvs_neg;
  logic [XLEN-1:0]  w_dvd_abs;
  logic [XLEN-1:0]  w_dvs_abs;
  logic [XLEN:0]    w_shift_rem;
  logic [XLEN:0]    w_trial;

  assign w_dvd_neg = i_signed & i_dividend[XLEN-1];
  assign w_dvs_neg = i_signed & i_divisor[XLEN-1];
  assign w_dvd_abs = w_dvd_neg ? -i_dividend : i_dividend;
  assign w_dvs_abs = w_dvs_neg ? -i_divisor : i_divisor;

  // Quotient register doubles as the dividend shift register.
  assign w_shift_rem = {r_rem, r_quo[XLEN-1]};
  assign w_trial     = w_shift_rem - {1'b0, r_dvs};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= DIV_IDLE;
      r_cnt   <= '0;
      r_quo   <= '0;
      r_rem   <= '0;
      r_dvs   <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
    end else begin
      case (r_state)
        DIV_IDLE: begin
          if (i_start) begin
            r_cnt <= '0;
            if (i_divisor == '0) begin
              r_quo   <= '1;
              r_rem   <= i_dividend;
              r_neg_q <= 1'b0;
              r_neg_r <= 1'b0;
              r_state <= DIV_DONE;
            end else begin
              r_quo   <= w_dvd_abs;
              r_rem   <= '0;
              r_dvs   <= w_dvs_abs;
              r_neg_q <= w_dvd_neg ^ w_dvs_neg;
              r_neg_r <= w_dvd_neg;
              r_state <= DIV_BUSY;
            end
          end
        end
        DIV_BUSY: begin
          if (!i_start) begin
            r_state <= DIV_IDLE;
          end else begin
            r_rem <= w_trial[XLEN] ? w_shift_rem[XLEN-1:0] : w_trial[XLEN-1:0];
            r_quo <= {r_quo[XLEN-2:0], ~w_trial[XLEN]};
            r_cnt <= r_cnt + CNT_W'(1);
            if (r_cnt == CNT_W'(DIV_STEPS - 1)) begin
              r_state <= DIV_DONE;
            end
          end
        end
        DIV_DONE: r_state <= DIV_IDLE;
        default:  r_state <= DIV_IDLE;
      endcase
    end
  end

  assign o_busy      = i_start && ((r_state == DIV_IDLE) || (r_state == DIV_BUSY));
  assign o_done      = i_start && (r_state == DIV_DONE);
  assign o_quotient  = r_neg_q ? -r_quo : r_quo;
  assign o_remainder = r_neg_r ? -r_rem : r_rem;

endmodule

// File: rtl/exe_stage.sv
// MIPS32 execute stage: combinational ALU/shift/move/jump/multiply, iterative divide with stall request.
module exe_stage
  import mips32_defs::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  exe_alutype,
  input  logic [7:0]  exe_aluop,
  input  logic [31:0] exe_src1,
  input  logic [31:0] exe_src2,
  input  logic [4:0]  exe_wa,
  input  logic        exe_wreg,
  input  logic        exe_mreg,
  input  logic        exe_whilo,
  input  logic [31:0] exe_din,
  input  logic [31:0] exe_ret_addr,
  input  logic [31:0] hi_i,
  input  logic [31:0] lo_i,
  input  logic        mem2exe_whilo,
  input  logic [63:0] mem2exe_hilo,
  output logic [7:0]  exe_aluop_o,
  output logic [4:0]  exe_wa_o,
  output logic        exe_wreg_o,
  output logic        exe_mreg_o,
  output logic        exe_whilo_o,
  output logic [31:0] exe_wd_o,
  output logic [31:0] exe_din_o,
  output logic [63:0] exe_hilo_o,
  output logic        stallreq_exe
);

  logic            w_is_div;
  logic            w_div_busy;
  logic            w_div_done;
  logic [31:0]     w_quo;
  logic [31:0]     w_rem;
  logic [31:0]     w_hi;
  logic [31:0]     w_lo;
  logic [31:0]     w_wd;
  logic [63:0]     w_hilo;
  logic [63:0]     w_mul_s;
  logic [63:0]     w_mul_u;

  assign w_is_div = is_div(exe_aluop);

  div_iter u_div (
    .clk         (clk),
    .rst         (rst),
    .i_start     (w_is_div),
    .i_signed    (exe_aluop == ALU_DIV),
    .i_dividend  (exe_src1),
    .i_divisor   (exe_src2),
    .o_busy      (w_div_busy),
    .o_done      (w_div_done),
    .o_quotient  (w_quo),
    .o_remainder (w_rem)
  );

  // HI/LO forwarded from MEM when a write there is still pending.
  assign w_hi = mem2exe_whilo ? mem2exe_hilo[63:32] : hi_i;
  assign w_lo = mem2exe_whilo ? mem2exe_hilo[31:0]  : lo_i;

  assign w_mul_s = $signed({{32{exe_src1[31]}}, exe_src1}) * $signed({{32{exe_src2[31]}}, exe_src2});
  assign w_mul_u = {32'h0, exe_src1} * {32'h0, exe_src2};

  always_comb begin
    w_wd = '0;
    case (exe_alutype)
      ALUTYPE_ARITH: begin
        case (exe_aluop)
          ALU_ADD, ALU_ADDU: w_wd = exe_src1 + exe_src2;
          ALU_SUB, ALU_SUBU: w_wd = exe_src1 - exe_src2;
          ALU_SLT:           w_wd = {31'h0, $signed(exe_src1) < $signed(exe_src2)};
          ALU_SLTU:          w_wd = {31'h0, exe_src1 < exe_src2};
          default:           w_wd = '0;
        endcase
      end
      ALUTYPE_LOGIC: begin
        case (exe_aluop)
          ALU_AND: w_wd = exe_src1 & exe_src2;
          ALU_OR:  w_wd = exe_src1 | exe_src2;
          ALU_XOR: w_wd = exe_src1 ^ exe_src2;
          ALU_NOR: w_wd = ~(exe_src1 | exe_src2);
          ALU_LUI: w_wd = {exe_src2[15:0], 16'h0};
          default: w_wd = '0;
        endcase
      end
      ALUTYPE_SHIFT: begin
        case (exe_aluop)
          ALU_SLL: w_wd = exe_src2 << exe_src1[4:0];
          ALU_SRL: w_wd = exe_src2 >> exe_src1[4:0];
          ALU_SRA: w_wd = 32'($signed(exe_src2) >>> exe_src1[4:0]);
          default: w_wd = '0;
        endcase
      end
      ALUTYPE_MOVE: begin
        case (exe_aluop)
          ALU_MFHI: w_wd = w_hi;
          ALU_MFLO: w_wd = w_lo;
          default:  w_wd = '0;
        endcase
      end
      ALUTYPE_JUMP: w_wd = exe_ret_addr;
      default:      w_wd = '0;
    endcase
  end

  always_comb begin
    w_hilo = '0;
    if (exe_aluop == ALU_MULT) begin
      w_hilo = w_mul_s;
    end else if (exe_aluop == ALU_MULTU) begin
      w_hilo = w_mul_u;
    end else if (w_div_done) begin
      w_hilo = {w_rem, w_quo};
    end
  end

  // Everything reads as zero while reset is held.
  always_comb begin
    exe_aluop_o  = '0;
    exe_wa_o     = '0;
    exe_wreg_o   = 1'b0;
    exe_mreg_o   = 1'b0;
    exe_whilo_o  = 1'b0;
    exe_wd_o     = '0;
    exe_din_o    = '0;
    exe_hilo_o   = '0;
    stallreq_exe = 1'b0;
    if (!rst) begin
      exe_aluop_o  = exe_aluop;
      exe_wa_o     = exe_wa;
      exe_wreg_o   = exe_wreg;
      exe_mreg_o   = exe_mreg;
      exe_whilo_o  = exe_whilo & (~w_is_div | w_div_done);
      exe_wd_o     = w_wd;
      exe_din_o    = exe_din;
      exe_hilo_o   = w_hilo;
      stallreq_exe = w_div_busy;
    end
  end

endmodule
